mdu_ctrl: RTL and testbench

- Sequencer for the multiply/divide unit (Mul) in the MIPS core; sits between ID-stage decode and the Mul datapath.
- Translates decoded MULT/DIV/MFHI/MFLO/MTHI/MTLO requests into Mul control strobes and enforces minimum operation latency.
- Stalls the pipeline while an operation is in flight and flags divide-by-zero and timeout.

---
 rtl/mdu_pkg.sv | 41 ++++
 rtl/mdu_if.sv | 30 +++
 rtl/mdu_lat_counter.sv | 35 +++
 rtl/mdu_ctrl.sv | 158 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// select encodings, counter commands and the counter width helper.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_MULT = 3'd1,
      OP_DIV  = 3'd2,
      OP_MFHI = 3'd3,
      OP_MFLO = 3'd4,
      OP_MTHI = 3'd5,
      OP_MTLO = 3'd6
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      WAIT = 2'd2
   } mdu_state_e;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_LOAD = 2'd1,
      CNT_DEC  = 2'd2,
      CNT_INC  = 2'd3
   } cnt_cmd_e;

   localparam logic SEL_HIGH = 1'b1;
   localparam logic SEL_LOW  = 1'b0;
   localparam logic MD_MUL   = 1'b0;
   localparam logic MD_DIV   = 1'b1;

   // One counter serves both the latency count-down and the timeout count-up,
   // so it must hold the larger of the two limits.
   function automatic int cnt_width(input int div_cycles, input int timeout);
      int m;
      m = (div_cycles > timeout) ? div_cycles : timeout;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/strobe bundle between ID-stage decode, the sequencer and the Mul
// datapath. master = decode/datapath side, slave = mdu_ctrl.
interface mdu_if;
   logic       Op_Valid;
   logic [2:0] Op;
   logic       Op_Flush;
   logic       Op_B_Zero;
   logic       MUL_Flag;
   logic       MUL_Start;
   logic       MUL_SelMD;
   logic       MUL_SelHL;
   logic       MUL_Write;
   logic       Stall;
   logic       Rd_Valid;
   logic       Busy;
   logic       Err_DivZero;
   logic       Err_Timeout;

   modport master (
      output Op_Valid, Op, Op_Flush, Op_B_Zero, MUL_Flag,
      input  MUL_Start, MUL_SelMD, MUL_SelHL, MUL_Write, Stall, Rd_Valid,
             Busy, Err_DivZero, Err_Timeout
   );

   modport slave (
      input  Op_Valid, Op, Op_Flush, Op_B_Zero, MUL_Flag,
      output MUL_Start, MUL_SelMD, MUL_SelHL, MUL_Write, Stall, Rd_Valid,
             Busy, Err_DivZero, Err_Timeout
   );
endinterface

// File: rtl/mdu_lat_counter.sv
// Loadable down-counter with a zero flag; also counts up for the timeout
// window so the sequencer needs only one counter register.
module mdu_lat_counter
   import mdu_pkg::*;
#(
   parameter int WIDTH = 7
) (
   input  logic             Clk,
   input  logic             Reset,
   input  cnt_cmd_e         Cmd,
   input  logic [WIDTH-1:0] Load_Val,
   output logic [WIDTH-1:0] Count,
   output logic             Zero
);

   logic [WIDTH-1:0] count_reg;

   // Count register: load, saturating decrement, or increment per command.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_reg <= '0;
      end else begin
         case (Cmd)
            CNT_LOAD: count_reg <= Load_Val;
            CNT_DEC:  if (count_reg != '0) count_reg <= count_reg - WIDTH'(1);
            CNT_INC:  count_reg <= count_reg + WIDTH'(1);
            default:  count_reg <= count_reg;
         endcase
      end
   end

   assign Count = count_reg;
   assign Zero  = (count_reg == '0);

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: turns decoded MDU ops into Mul strobes, enforces
// the minimum operation latency, stalls ID while busy and flags errors.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 33,
   parameter int TIMEOUT    = 64
) (
   input logic   Clk,
   input logic   Reset,
   mdu_if.slave  bus
);

   localparam int            CW       = cnt_width(DIV_CYCLES, TIMEOUT);
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

   mdu_state_e    state_reg;
   logic          start_reg;
   logic          sel_md_reg;
   logic          sel_hl_reg;
   logic          write_reg;
   logic          div_zero_reg;
   logic          timeout_reg;

   cnt_cmd_e      cnt_cmd;
   logic [CW-1:0] cnt_load;
   logic [CW-1:0] cnt_val;
   logic          cnt_zero;

   logic          req;
   logic          idle;
   logic          is_mf;
   logic          issue_mul;
   logic          issue_div;
   logic          timeout_hit;

   assign req         = bus.Op_Valid && !bus.Op_Flush && (bus.Op != OP_NONE);
   assign idle        = (state_reg == IDLE);
   assign is_mf       = (bus.Op == OP_MFHI) || (bus.Op == OP_MFLO);
   assign issue_mul   = idle && req && (bus.Op == OP_MULT);
   assign issue_div   = idle && req && (bus.Op == OP_DIV) && !bus.Op_B_Zero;
   // The timeout fires on the cycle whose increment would reach TIMEOUT.
   assign timeout_hit = (state_reg == WAIT) && !bus.MUL_Flag && (cnt_val == TO_LAST);

   mdu_lat_counter #(.WIDTH(CW)) u_cnt (
      .Clk      (Clk),
      .Reset    (Reset),
      .Cmd      (cnt_cmd),
      .Load_Val (cnt_load),
      .Count    (cnt_val),
      .Zero     (cnt_zero)
   );

   // Counter control: load latency on issue, count down in BUSY, count up in
   // WAIT, and clear on leaving WAIT so IDLE always sees a zero counter.
   always_comb begin
      cnt_cmd  = CNT_HOLD;
      cnt_load = '0;
      case (state_reg)
         IDLE: begin
            if (issue_mul) begin
               cnt_cmd  = CNT_LOAD;
               cnt_load = MUL_LOAD;
            end else if (issue_div) begin
               cnt_cmd  = CNT_LOAD;
               cnt_load = DIV_LOAD;
            end
         end
         BUSY: begin
            if (!cnt_zero) cnt_cmd = CNT_DEC;
         end
         WAIT: begin
            if (bus.MUL_Flag || timeout_hit) cnt_cmd = CNT_LOAD;
            else                             cnt_cmd = CNT_INC;
         end
         default: cnt_cmd = CNT_HOLD;
      endcase
   end

   // Sequencer FSM with registered strobes; one-cycle strobes default low.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg    <= IDLE;
         start_reg    <= 1'b0;
         sel_md_reg   <= MD_MUL;
         sel_hl_reg   <= SEL_LOW;
         write_reg    <= 1'b0;
         div_zero_reg <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         start_reg    <= 1'b0;
         write_reg    <= 1'b0;
         div_zero_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req) begin
                  case (bus.Op)
                     OP_MULT: begin
                        start_reg  <= 1'b1;
                        sel_md_reg <= MD_MUL;
                        state_reg  <= BUSY;
                     end
                     OP_DIV: begin
                        if (bus.Op_B_Zero) begin
                           div_zero_reg <= 1'b1;
                        end else begin
                           start_reg  <= 1'b1;
                           sel_md_reg <= MD_DIV;
                           state_reg  <= BUSY;
                        end
                     end
                     OP_MTHI: begin
                        write_reg  <= 1'b1;
                        sel_hl_reg <= SEL_HIGH;
                     end
                     OP_MTLO: begin
                        write_reg  <= 1'b1;
                        sel_hl_reg <= SEL_LOW;
                     end
                     default: ;
                  endcase
               end
            end
            BUSY: begin
               if (cnt_zero) begin
                  if (bus.MUL_Flag) state_reg <= IDLE;
                  else              state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (bus.MUL_Flag) begin
                  state_reg <= IDLE;
               end else if (timeout_hit) begin
                  timeout_reg <= 1'b1;
                  state_reg   <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.MUL_Start   = start_reg;
   assign bus.MUL_SelMD   = sel_md_reg;
   // An accepted MF read steers HI/LO directly; otherwise hold the last MT select.
   assign bus.MUL_SelHL   = (idle && req && is_mf) ? (bus.Op == OP_MFHI) : sel_hl_reg;
   assign bus.MUL_Write   = write_reg;
   assign bus.Stall       = req && !idle;
   assign bus.Rd_Valid    = idle && req && is_mf && bus.MUL_Flag;
   // The start cycle is excluded so Busy and MUL_Start never overlap.
   assign bus.Busy        = !idle && !start_reg;
   assign bus.Err_DivZero = div_zero_reg;
   assign bus.Err_Timeout = timeout_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: a cycle-indexed transaction model predicts strobes into a
// queue and per-cycle Busy/Stall/timeout levels; a negedge monitor compares.
`timescale 1ns/1ps
module tb_mdu_ctrl;
   import mdu_pkg::*;

   localparam int MUL_N = 4;
   localparam int DIV_N = 33;
   localparam int TMO   = 64;
   localparam int NEVER = 1000000000;

   typedef enum int {EV_START, EV_WRITE, EV_DZ, EV_RD} ev_kind_e;
   typedef struct {
      int       cyc;
      ev_kind_e kind;
      bit       sel;
   } ev_t;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;
   mdu_if bus ();

   mdu_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .TIMEOUT(TMO)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_err = 0;

   // Model state: cycle numbers of the operation in flight.
   int  idle_from  = 0;
   int  cur_s      = NEVER;
   int  f_cyc      = NEVER;
   int  timeout_at = NEVER;
   bit  have_op    = 1'b0;
   bit  cur_md     = 1'b0;
   int  drive_k    = -1;
   int  reset_chk  = -1;
   bit  skip_k     = 1'b1;
   bit  exp_busy   = 1'b0;
   bit  exp_stall  = 1'b0;
   bit  exp_tmo    = 1'b0;
   bit  last_stalled = 1'b0;
   bit  last_was_mt  = 1'b0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic push_ev(input int c, input ev_kind_e kd, input bit s);
      ev_t e;
      e.cyc  = c;
      e.kind = kd;
      e.sel  = s;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs and advance the model. d = flag delay after start.
   task automatic drive(input bit v, input bit fl, input logic [2:0] o, input bit bz,
                        input int d, input bit rst);
      int k;
      int n;
      bit flag_now;
      bit req;
      bit idle_k;
      @(posedge Clk);
      #1;
      k        = cyc;
      flag_now = have_op && (k >= f_cyc);
      Reset          = rst;
      bus.Op_Valid   = v;
      bus.Op_Flush   = fl;
      bus.Op         = o;
      bus.Op_B_Zero  = bz;
      bus.MUL_Flag   = flag_now;
      drive_k        = k;
      skip_k         = rst;
      if (rst) begin
         exp_q.delete();
         have_op      = 1'b0;
         f_cyc        = NEVER;
         timeout_at   = NEVER;
         cur_s        = NEVER;
         cur_md       = 1'b0;
         idle_from    = k + 1;
         reset_chk    = k + 1;
         last_stalled = 1'b0;
         last_was_mt  = 1'b0;
         return;
      end
      req       = v && !fl && (o != OP_NONE);
      idle_k    = (k >= idle_from);
      exp_stall = req && !idle_k;
      exp_busy  = (k > cur_s) && (k < idle_from);
      exp_tmo   = (k >= timeout_at);
      last_stalled = exp_stall;
      last_was_mt  = 1'b0;
      if (req && idle_k) begin
         case (o)
            OP_MULT, OP_DIV: begin
               if (o == OP_DIV && bz) begin
                  push_ev(k + 1, EV_DZ, 1'b0);
               end else begin
                  n       = (o == OP_MULT) ? MUL_N : DIV_N;
                  cur_s   = k + 1;
                  cur_md  = (o == OP_DIV);
                  have_op = 1'b1;
                  f_cyc   = cur_s + d;
                  push_ev(cur_s, EV_START, cur_md);
                  if (f_cyc <= cur_s + n - 1)            idle_from = cur_s + n;
                  else if (f_cyc <= cur_s + n + TMO - 1) idle_from = f_cyc + 1;
                  else begin
                     idle_from = cur_s + n + TMO;
                     if (timeout_at == NEVER) timeout_at = idle_from;
                  end
               end
            end
            OP_MTHI, OP_MTLO: begin
               push_ev(k + 1, EV_WRITE, o == OP_MTHI);
               last_was_mt = 1'b1;
            end
            OP_MFHI, OP_MFLO: begin
               if (flag_now) push_ev(k, EV_RD, o == OP_MFHI);
            end
            default: ;
         endcase
      end
   endtask

   task automatic idle_cycles(input int cnt);
      for (int i = 0; i < cnt; i++) drive(1'b0, 1'b0, OP_NONE, 1'b0, 0, 1'b0);
   endtask

   task automatic do_reset(input int cnt);
      for (int i = 0; i < cnt; i++) drive(1'b0, 1'b0, OP_NONE, 1'b0, 0, 1'b1);
      idle_cycles(1);
   endtask

   bit m_start, m_write, m_dz, m_rd, m_md, m_whl, m_rhl;
   ev_t m_e;

   // Monitor: pop every event due this cycle and compare all outputs.
   always @(negedge Clk) begin
      if (drive_k == cyc && !skip_k) begin
         m_start = 1'b0; m_write = 1'b0; m_dz = 1'b0; m_rd = 1'b0;
         m_md = 1'b0; m_whl = 1'b0; m_rhl = 1'b0;
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            m_e = exp_q.pop_front();
            case (m_e.kind)
               EV_START: begin m_start = 1'b1; m_md  = m_e.sel; end
               EV_WRITE: begin m_write = 1'b1; m_whl = m_e.sel; end
               EV_DZ:    m_dz = 1'b1;
               default:  begin m_rd = 1'b1; m_rhl = m_e.sel; end
            endcase
         end
         chk("mul_start", 16'(bus.MUL_Start), 16'(m_start));
         if (m_start) chk("sel_md_start", 16'(bus.MUL_SelMD), 16'(m_md));
         chk("mul_write", 16'(bus.MUL_Write), 16'(m_write));
         if (m_write) chk("sel_hl_write", 16'(bus.MUL_SelHL), 16'(m_whl));
         chk("err_divzero", 16'(bus.Err_DivZero), 16'(m_dz));
         chk("rd_valid", 16'(bus.Rd_Valid), 16'(m_rd));
         if (m_rd) chk("sel_hl_read", 16'(bus.MUL_SelHL), 16'(m_rhl));
         chk("stall", 16'(bus.Stall), 16'(exp_stall));
         chk("busy", 16'(bus.Busy), 16'(exp_busy));
         chk("err_timeout", 16'(bus.Err_Timeout), 16'(exp_tmo));
         if (exp_busy) chk("sel_md_hold", 16'(bus.MUL_SelMD), 16'(cur_md));
         if (cyc == reset_chk)
            chk("reset_outputs",
                16'({bus.MUL_Start, bus.MUL_SelMD, bus.MUL_SelHL, bus.MUL_Write, bus.Stall,
                     bus.Rd_Valid, bus.Busy, bus.Err_DivZero, bus.Err_Timeout}),
                16'h0);
      end
   end

   logic [2:0] op_r = 3'd0;
   bit         v_r  = 1'b0;
   bit         fl_r = 1'b0;
   bit         bz_r = 1'b0;
   int         d_r  = 1;

   initial begin
      bus.Op_Valid  = 1'b0;
      bus.Op_Flush  = 1'b0;
      bus.Op        = OP_NONE;
      bus.Op_B_Zero = 1'b0;
      bus.MUL_Flag  = 1'b0;

      do_reset(2);

      // MULT with flag 4 cycles after start; MFLO re-presented until accepted.
      drive(1'b1, 1'b0, OP_MULT, 1'b0, MUL_N, 1'b0);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, OP_MFLO, 1'b0, 0, 1'b0);
         if (!last_stalled) break;
      end
      idle_cycles(2);

      // DIV by zero.
      drive(1'b1, 1'b0, OP_DIV, 1'b1, 0, 1'b0);
      idle_cycles(3);

      // MTHI then MTLO back to back.
      drive(1'b1, 1'b0, OP_MTHI, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, OP_MTLO, 1'b0, 0, 1'b0);
      idle_cycles(2);

      // Flushed MULT while idle.
      drive(1'b1, 1'b1, OP_MULT, 1'b0, MUL_N, 1'b0);
      idle_cycles(3);

      // DIV whose flag never arrives: timeout, then stays set across a new op.
      drive(1'b1, 1'b0, OP_DIV, 1'b0, NEVER, 1'b0);
      idle_cycles(DIV_N + TMO + 5);
      drive(1'b1, 1'b0, OP_MULT, 1'b0, 2, 1'b0);
      idle_cycles(8);
      do_reset(1);

      // Reset ten cycles into a DIV, then a normal MULT.
      drive(1'b1, 1'b0, OP_DIV, 1'b0, DIV_N, 1'b0);
      idle_cycles(10);
      do_reset(1);
      drive(1'b1, 1'b0, OP_MULT, 1'b0, MUL_N, 1'b0);
      idle_cycles(8);

      // Random op stream; stalled ops are re-presented like the pipeline does.
      for (int i = 0; i < 800; i++) begin
         if (!last_stalled) begin
            v_r  = ($urandom_range(0, 9) < 7);
            op_r = 3'($urandom_range(0, 6));
            bz_r = ($urandom_range(0, 3) == 0);
            if (last_was_mt && (op_r == OP_MFHI || op_r == OP_MFLO)) op_r = OP_MTLO;
         end
         fl_r = ($urandom_range(0, 9) == 0);
         if (op_r == OP_MULT) d_r = int'($urandom_range(1, MUL_N + 3));
         else                 d_r = int'($urandom_range(1, DIV_N + 3));
         drive(v_r, fl_r, op_r, bz_r, d_r, 1'b0);
      end
      idle_cycles(DIV_N + 10);

      chk("queue_drained", 16'(exp_q.size()), 16'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
